// File: rtl/shiftregin_loader_pkg.sv
// Shared constants and types for the input shift-register loader and its
// beat counter.
package shiftregin_loader_pkg;

    localparam int unsigned N_LANES   = 40;
    localparam int unsigned HOLD_ADDR = 63;
    localparam int unsigned CNT_W     = 6;

    localparam logic SR_SHIFT = 1'b0;
    localparam logic SR_ADDR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        FIN   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/shiftregin_loader_beat_counter.sv
// Beat counter with synchronous clear, enable and a terminal flag at N-1;
// shared by the loader and the output-side unloader.
module loader_beat_counter
    import shiftregin_loader_pkg::*;
#(
    parameter int unsigned N = N_LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign last_c = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/shiftregin_loader.sv
// Converts a valid/ready word stream into one frame of shift-register
// control (shift-in through lane 0 or addressed lane writes).
module shiftregin_loader
    import shiftregin_loader_pkg::*;
#(
    parameter int unsigned B         = 8,
    parameter int unsigned N         = N_LANES,
    parameter int unsigned HOLD_ADDR = shiftregin_loader_pkg::HOLD_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_mode,
    input  logic             cfg_clear,
    input  logic             abort,
    input  logic [B-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [B-1:0]     sr_in0,
    output logic [B-1:0]     sr_in1,
    output logic [CNT_W-1:0] sr_addr,
    output logic             sr_mode,
    output logic             sr_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    loader_state_e    state_q, state_d;
    logic             mode_q, mode_d;
    logic [B-1:0]     sr_in0_q, sr_in0_d;
    logic [B-1:0]     sr_in1_q, sr_in1_d;
    logic [CNT_W-1:0] sr_addr_q, sr_addr_d;
    logic             sr_mode_q, sr_mode_d;
    logic             sr_rst_q, sr_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_last;
    logic             beat;

    // Ready depends only on state; abort blocks any beat in its own cycle.
    assign s_ready = (state_q == LOAD) && !abort;
    assign beat    = s_ready && s_valid;

    loader_beat_counter #(.N(N)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (beat),
        .cnt    (cnt),
        .last_c (cnt_last)
    );

    // Next state and next registered outputs; hold encoding is the default.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sr_in0_d  = sr_in0_q;
        sr_in1_d  = sr_in1_q;
        sr_addr_d = CNT_W'(HOLD_ADDR);
        sr_mode_d = SR_ADDR;
        sr_rst_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d  = cfg_mode;
                        cnt_clr = 1'b1;
                        busy_d  = 1'b1;
                        if (cfg_clear) begin
                            state_d  = CLEAR;
                            sr_rst_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                CLEAR: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    if (beat) begin
                        if (mode_q == SR_SHIFT) begin
                            sr_in0_d  = s_data;
                            sr_mode_d = SR_SHIFT;
                            sr_addr_d = '0;
                        end else begin
                            sr_in1_d  = s_data;
                            sr_addr_d = cnt;
                        end
                        if (cnt_last) begin
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= SR_SHIFT;
            sr_in0_q  <= '0;
            sr_in1_q  <= '0;
            sr_addr_q <= CNT_W'(HOLD_ADDR);
            sr_mode_q <= SR_ADDR;
            sr_rst_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sr_in0_q  <= sr_in0_d;
            sr_in1_q  <= sr_in1_d;
            sr_addr_q <= sr_addr_d;
            sr_mode_q <= sr_mode_d;
            sr_rst_q  <= sr_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sr_in0  = sr_in0_q;
    assign sr_in1  = sr_in1_q;
    assign sr_addr = sr_addr_q;
    assign sr_mode = sr_mode_q;
    assign sr_rst  = sr_rst_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shiftregin_loader.sv
// Bench for shiftregin_loader: control table, scoreboarded frames in both
// load styles, clear, abort, start-while-busy and mid-frame async reset.
module tb_shiftregin_loader;

    localparam int NL = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cfg_mode, cfg_clear, abort;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] sr_in0, sr_in1;
    logic [5:0] sr_addr;
    logic       sr_mode, sr_rst, busy, done;
    logic [5:0] cnt;

    shiftregin_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_mode  (cfg_mode),
        .cfg_clear (cfg_clear),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sr_in0    (sr_in0),
        .sr_in1    (sr_in1),
        .sr_addr   (sr_addr),
        .sr_mode   (sr_mode),
        .sr_rst    (sr_rst),
        .busy      (busy),
        .done      (done),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic start, mode, clr, abort, valid;
        logic exp_ready, exp_busy, exp_rst;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] lanes [NL];
    logic [7:0] words [NL];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_seen = 0;
    int         rst_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write-cycle scoreboard plus a model of the 40-lane register downstream.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_seen++;
            if (sr_rst) begin
                rst_seen++;
                for (int j = 0; j < NL; j++) lanes[j] = 8'h00;
            end
            if (sr_mode == 1'b0 || sr_addr != 6'd63) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got mode=%0d addr=%0d required hold at %0t",
                             sr_mode, sr_addr, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_mode", 32'(sr_mode), 32'(mon_e.mode));
                    check("wr_addr", 32'(sr_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(sr_mode ? sr_in1 : sr_in0), 32'(mon_e.data));
                end
                if (sr_mode == 1'b0) begin
                    for (int j = NL - 1; j > 0; j--) lanes[j] = lanes[j-1];
                    lanes[0] = sr_in0;
                end else if (int'(sr_addr) < NL) begin
                    lanes[sr_addr] = sr_in1;
                end
            end
        end
    end

    task automatic check_hold(input string name);
        check({name, "_mode"}, 32'(sr_mode), 32'(1));
        check({name, "_addr"}, 32'(sr_addr), 32'(63));
    endtask

    task automatic start_frame(input logic mode, input logic clr);
        start = 1'b1; cfg_mode = mode; cfg_clear = clr;
        step();
        start = 1'b0; cfg_mode = 1'b0; cfg_clear = 1'b0;
        if (clr) begin
            check("clear_ready", 32'(s_ready), 32'(0));
            check("clear_rst", 32'(sr_rst), 32'(1));
            step();
            check("clear_rst_end", 32'(sr_rst), 32'(0));
        end
    endtask

    task automatic drive_beat(input logic mode, input int k, input logic [7:0] d);
        exp_t e;
        s_valid = 1'b1;
        s_data  = d;
        #1;
        check("beat_ready", 32'(s_ready), 32'(1));
        e.mode = mode;
        e.addr = mode ? 6'(k) : 6'd0;
        e.data = d;
        sb.push_back(e);
        step();
    endtask

    // Called in the FIN cycle, right after the last beat's edge.
    task automatic finish_frame();
        int d0;
        d0 = done_seen;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        #1;
        check("fin_ready", 32'(s_ready), 32'(0));
        check("fin_busy", 32'(busy), 32'(1));
        check("fin_done", 32'(done), 32'(0));
        step();
        s_valid = 1'b0;
        check("done_pulse", 32'(done), 32'(1));
        check("done_busy", 32'(busy), 32'(0));
        check("done_cnt", 32'(cnt), 32'(NL));
        check_hold("done_hold");
        step();
        check("done_end", 32'(done), 32'(0));
        check("done_count", 32'(done_seen - d0), 32'(1));
        check("sb_empty", 32'(sb.size()), 32'(0));
    endtask

    task automatic run_addr_frame(input logic [7:0] base);
        start_frame(1'b1, 1'b0);
        for (int k = 0; k < NL; k++) drive_beat(1'b1, k, base + 8'(k));
        finish_frame();
        for (int k = 0; k < NL; k++) check("addr_lane", 32'(lanes[k]), 32'(base + 8'(k)));
    endtask

    initial begin
        vec_t tbl[9];
        int   r0, d0;

        rst_n = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_clear = 1'b0;
        abort = 1'b0; s_data = 8'h00; s_valid = 1'b0;
        for (int j = 0; j < NL; j++) lanes[j] = 8'h00;

        // Reset values while held and after release.
        #12;
        check_hold("rst_hold");
        check("rst_ready", 32'(s_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in0", 32'(sr_in0), 32'(0));
        check("rst_cnt", 32'(cnt), 32'(0));
        #10 rst_n = 1'b1;
        step();
        step();
        check_hold("idle_hold");
        check("idle_ready", 32'(s_ready), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_rst", 32'(sr_rst), 32'(0));

        // Control table: start/abort priority, clear cycle, start while busy.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start; cfg_mode = tbl[i].mode; cfg_clear = tbl[i].clr;
            abort = tbl[i].abort; s_valid = tbl[i].valid; s_data = 8'hA5;
            #1;
            check("tbl_ready", 32'(s_ready), 32'(tbl[i].exp_ready));
            step();
            check("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
            check("tbl_rst", 32'(sr_rst), 32'(tbl[i].exp_rst));
            check("tbl_done", 32'(done), 32'(0));
            check("tbl_cnt", 32'(cnt), 32'(0));
            check_hold("tbl_hold");
        end
        start = 1'b0; cfg_mode = 1'b0; cfg_clear = 1'b0; abort = 1'b0; s_valid = 1'b0;
        step();

        // Addressed load, continuous stream.
        run_addr_frame(8'h10);

        // Shift load with a one-cycle gap between beats.
        start_frame(1'b0, 1'b0);
        for (int k = 0; k < NL; k++) begin
            words[k] = 8'($urandom_range(0, 255));
            drive_beat(1'b0, k, words[k]);
            if (k < NL - 1) begin
                s_valid = 1'b0;
                step();
                check_hold("gap_hold");
            end
        end
        finish_frame();
        for (int k = 0; k < NL; k++) check("shift_lane", 32'(lanes[NL-1-k]), 32'(words[k]));

        // Clear cycle ahead of an addressed load; stream already valid.
        r0 = rst_seen;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        start_frame(1'b1, 1'b1);
        for (int k = 0; k < NL; k++) drive_beat(1'b1, k, 8'h60 + 8'(k));
        finish_frame();
        check("clear_count", 32'(rst_seen - r0), 32'(1));

        // Abort after 17 beats, then a complete frame.
        d0 = done_seen;
        start_frame(1'b1, 1'b0);
        for (int k = 0; k < 17; k++) drive_beat(1'b1, k, 8'h40 + 8'(k));
        abort = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        #1;
        check("abort_ready", 32'(s_ready), 32'(0));
        step();
        abort = 1'b0; s_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_cnt", 32'(cnt), 32'(17));
        check("abort_rst", 32'(sr_rst), 32'(0));
        check_hold("abort_hold");
        step();
        step();
        check("abort_no_done", 32'(done_seen - d0), 32'(0));
        check("abort_sb", 32'(sb.size()), 32'(0));
        run_addr_frame(8'h80);

        // Start while busy is ignored; async reset at beat 20 discards the frame.
        d0 = done_seen;
        r0 = rst_seen;
        start_frame(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                start = 1'b1; cfg_mode = 1'b0; cfg_clear = 1'b1;
            end
            drive_beat(1'b1, k, 8'hC0 + 8'(k));
            start = 1'b0; cfg_mode = 1'b0; cfg_clear = 1'b0;
        end
        check("busy_cnt", 32'(cnt), 32'(20));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_hold("arst_hold");
        check("arst_in0", 32'(sr_in0), 32'(0));
        check("arst_in1", 32'(sr_in1), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_cnt", 32'(cnt), 32'(0));
        check("arst_ready", 32'(s_ready), 32'(0));
        step();
        step();
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        check("arst_no_done", 32'(done_seen - d0), 32'(0));
        check("arst_no_clear", 32'(rst_seen - r0), 32'(0));
        check("arst_sb", 32'(sb.size()), 32'(0));
        check("arst_idle_busy", 32'(busy), 32'(0));
        check_hold("arst_idle_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
